// File: rtl/vga_frame_reader.sv
// VGA frame reader: 640x480@60 timing, 4x upscale of a 160x120 RGB332 framebuffer,
// RGB332 -> RGB444 expansion. Three-stage pipeline: counters, address, RAM data, pins.
module vga_frame_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] DP_RAM_addr_out,
  input  logic [7:0]        DP_RAM_data_out,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FP + V_SYNC);

  // Stage 0: raster counters
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Stage 0 decode
  logic              active_s0;
  logic              hsync_s0;
  logic              vsync_s0;
  logic              first_s0;
  logic [ADDR_W-1:0] addr_s0;

  // Stages 1 and 2 carry timing alongside the RAM access
  logic active_s1_q, hsync_s1_q, vsync_s1_q, first_s1_q;
  logic active_s2_q, hsync_s2_q, vsync_s2_q, first_s2_q;

  // Raster counters: h wraps every line, v advances on h wrap and wraps at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0 decode: visibility, raw syncs, first-pixel marker and framebuffer address
  always_comb begin
    active_s0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_s0  = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    vsync_s0  = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    first_s0  = (h_cnt == '0) && (v_cnt == '0);
    // 4x replication: drop the two LSBs of each counter
    addr_s0   = ADDR_W'(v_cnt >> 2) * ADDR_W'(FB_WIDTH) + ADDR_W'(h_cnt >> 2);
  end

  // Stage 1: issue the RAM address (0 while blanked) and delay timing
  always_ff @(posedge clk) begin
    if (rst) begin
      DP_RAM_addr_out <= '0;
      active_s1_q     <= 1'b0;
      hsync_s1_q      <= 1'b1;
      vsync_s1_q      <= 1'b1;
      first_s1_q      <= 1'b0;
    end else begin
      DP_RAM_addr_out <= active_s0 ? addr_s0 : '0;
      active_s1_q     <= active_s0;
      hsync_s1_q      <= hsync_s0;
      vsync_s1_q      <= vsync_s0;
      first_s1_q      <= first_s0;
    end
  end

  // Stage 2: wait out the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      active_s2_q <= 1'b0;
      hsync_s2_q  <= 1'b1;
      vsync_s2_q  <= 1'b1;
      first_s2_q  <= 1'b0;
    end else begin
      active_s2_q <= active_s1_q;
      hsync_s2_q  <= hsync_s1_q;
      vsync_s2_q  <= vsync_s1_q;
      first_s2_q  <= first_s1_q;
    end
  end

  // Stage 3: expand RGB332 to RGB444 by replicating MSBs, blank outside the visible area
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_red     <= active_s2_q ? {DP_RAM_data_out[7:5], DP_RAM_data_out[7]} : 4'h0;
      vga_green   <= active_s2_q ? {DP_RAM_data_out[4:2], DP_RAM_data_out[4]} : 4'h0;
      vga_blue    <= active_s2_q ? {DP_RAM_data_out[1:0], DP_RAM_data_out[1:0]} : 4'h0;
      vga_hsync   <= hsync_s2_q;
      vga_vsync   <= vsync_s2_q;
      frame_start <= first_s2_q;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader. Full horizontal timing, shortened vertical timing so that
// complete frames fit in a short run. A raster model derived from elapsed clocks since
// reset release predicts every output on every cycle; literal checks pin the model.
module tb_vga_frame_reader;

  localparam int HV  = 640;
  localparam int HF  = 16;
  localparam int HS  = 96;
  localparam int HB  = 48;
  localparam int VV  = 24;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 4;
  localparam int FBW = 160;
  localparam int HT  = HV + HF + HS + HB;  // 800
  localparam int VT  = VV + VF + VS + VB;  // 32
  localparam int L   = HT * VT;            // 25600

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] addr;
  logic [7:0]  ram_data;
  logic        hs, vs, fs;
  logic [3:0]  r, g, b;

  vga_frame_reader #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_WIDTH(FBW), .ADDR_W(15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .DP_RAM_addr_out(addr),
    .DP_RAM_data_out(ram_data),
    .vga_hsync      (hs),
    .vga_vsync      (vs),
    .vga_red        (r),
    .vga_green      (g),
    .vga_blue       (b),
    .frame_start    (fs)
  );

  always #20 clk = ~clk;

  // RAM model: one clock read latency
  logic [7:0] mem [32768];
  always @(posedge clk) ram_data <= mem[addr];

  int tests = 0;
  int fails = 0;

  // Clocks since reset release: 0 while rst is held, first clock after release is 0
  int k = 0;
  bit k_valid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      k       <= 0;
      k_valid <= 1'b1;
    end else if (k_valid) begin
      k <= k + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Address visible at clock kk belongs to the pixel counted at kk-1
  function automatic int exp_addr(input int kk);
    int p, h, v;
    if (kk < 1) return 0;
    p = (kk - 1) % L;
    h = p % HT;
    v = p / HT;
    if (h < HV && v < VV) return (v / 4) * FBW + h / 4;
    return 0;
  endfunction

  // Pins at clock kk show the pixel counted at kk-3
  task automatic exp_pins(input int kk, output int ehs, output int evs, output int ergb,
                          output int efs);
    int p, h, v, by, rr, gg, bb;
    ehs = 1; evs = 1; ergb = 0; efs = 0;
    if (kk >= 3) begin
      p   = (kk - 3) % L;
      h   = p % HT;
      v   = p / HT;
      ehs = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
      evs = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
      efs = (p == 0) ? 1 : 0;
      if (h < HV && v < VV) begin
        by   = int'(mem[(v / 4) * FBW + h / 4]);
        rr   = by / 32;
        gg   = (by / 4) % 8;
        bb   = by % 4;
        ergb = (((rr * 2) + (rr / 4)) * 256) + (((gg * 2) + (gg / 4)) * 16) + bb * 5;
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int ehs, evs, ergb, efs;
    if (k_valid) begin
      exp_pins(k, ehs, evs, ergb, efs);
      check("addr", int'(addr), exp_addr(k));
      check("hsync", int'(hs), ehs);
      check("vsync", int'(vs), evs);
      check("rgb", int'({r, g, b}), ergb);
      check("frame_start", int'(fs), efs);
    end
  end

  // Timing monitor: edge offsets relative to the most recent frame_start
  int cyc = 0;
  int fs_cyc = -1;
  int period_last = -1;
  int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  always @(negedge clk) begin
    int off;
    cyc++;
    if (rst) begin
      fs_cyc = -1;
      period_last = -1;
    end else if (fs === 1'b1) begin
      if (fs_cyc >= 0) period_last = cyc - fs_cyc;
      fs_cyc = cyc;
      hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
    end else if (fs_cyc >= 0) begin
      off = cyc - fs_cyc;
      if (hs_prev === 1'b1 && hs === 1'b0 && hs_fall < 0) hs_fall = off;
      if (hs_prev === 1'b0 && hs === 1'b1 && hs_rise < 0) hs_rise = off;
      if (vs_prev === 1'b1 && vs === 1'b0 && vs_fall < 0) vs_fall = off;
      if (vs_prev === 1'b0 && vs === 1'b1 && vs_rise < 0) vs_rise = off;
    end
    hs_prev = hs;
    vs_prev = vs;
  end

  task automatic wait_k(input int target);
    int budget = 100000;
    while (k != target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (k != target) check("wait_timeout", k, target);
  endtask

  // Literal expectations after a reset release, then one full frame of timing
  task automatic run_checks();
    for (int kk = 0; kk < 3; kk++) begin
      wait_k(kk);
      check("idle_addr", int'(addr), 0);
      check("idle_hsync", int'(hs), 1);
      check("idle_vsync", int'(vs), 1);
      check("idle_rgb", int'({r, g, b}), 0);
      check("idle_fs", int'(fs), 0);
    end
    wait_k(3);
    check("fs_at_3", int'(fs), 1);
    check("rgb_E3", int'({r, g, b}), 12'hF0F);
    wait_k(5);
    check("addr_4_0", int'(addr), 1);
    wait_k(7);
    check("rgb_1C", int'({r, g, b}), 12'h0F0);
    wait_k(11);
    check("rgb_49", int'({r, g, b}), 12'h445);
    wait_k(641);
    check("addr_640_0", int'(addr), 0);
    wait_k(2404);
    check("addr_3_3", int'(addr), 0);
    wait_k(3201);
    check("addr_0_4", int'(addr), 160);
    wait_k(19040);
    check("addr_639_23", int'(addr), 959);
    wait_k(L + 2);
    check("hsync_fall", hs_fall, 656);
    check("hsync_rise", hs_rise, 752);
    check("vsync_fall", vs_fall, 20800);
    check("vsync_rise", vs_rise, 22400);
    wait_k(L + 4);
    check("fs_period", period_last, 25600);
  endtask

  initial begin
    int hold;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'hE3;
    mem[1] = 8'h1C;
    mem[2] = 8'h49;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    run_checks();

    // Mid-frame reset during an hsync pulse (line 12, h=700 of the second frame)
    wait_k(L + 12 * HT + 700);
    check("hsync_low_before_rst", int'(hs), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hsync_after_rst", int'(hs), 1);
    check("addr_after_rst", int'(addr), 0);
    hold = int'($urandom_range(1, 4));
    repeat (hold) @(posedge clk);
    #1 rst = 1'b0;
    run_checks();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the 160x120 RGB332 framebuffer that the camera capture stage writes into the dual-port RAM.
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
- Reads the RAM's read port, upscaling 4x in each axis (pixel replication).
- Expands RGB332 to 12-bit RGB444 for the VGA DAC pins.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_WIDTH, 160, framebuffer columns
- ADDR_W, 15, RAM address width

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- DP_RAM_addr_out  out  15  framebuffer read address
- DP_RAM_data_out  in  8  RAM read data, RGB332 {R[7:5],G[4:2],B[1:0]}; valid one clk after the address
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_red  out  4  red
- vga_green  out  4  green
- vga_blue  out  4  blue
- frame_start  out  1  one-clk pulse aligned with the first visible pixel (0,0) at the pins

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..524 and wraps to 0.
  - Frame length is exactly 420000 clks.
- Raw timing (stage 0):
  - active when h_cnt<640 and v_cnt<480.
  - hsync_raw=0 for h_cnt in 656..751, else 1.
  - vsync_raw=0 for v_cnt in 490..491, else 1.
- Address (stage 1, registered):
  - When active: DP_RAM_addr_out = (v_cnt>>2)*160 + (h_cnt>>2). Range 0..19199 (0x4AFF).
  - When not active: DP_RAM_addr_out = 0.
  - The multiply may be implemented as a line-base accumulator (+160 every 4th line). It must be bit-exact with the formula.
- RAM read (stage 2): DP_RAM_data_out is sampled for the address issued in stage 1.
- Colour (stage 3, registered):
  - vga_red = {R[2:0],R[2]}
  - vga_green = {G[2:0],G[2]}
  - vga_blue = {B[1:0],B[1:0]}
  - Outside the active region, all colour outputs = 0.
- Alignment:
  - active, hsync_raw and vsync_raw are delayed through the pipeline.
  - Pixel (h,v) from stage 0 at clk n appears on vga_* at n+3, with sync and blank aligned to it.
  - Fixed latency is 3 clks.
- frame_start:
  - Asserted for exactly 1 clk, at the clk where pixel (0,0) colour is on the pins.
  - That is 3 clks after h_cnt=0,v_cnt=0.
- Reset:
  - Counters go to 0 and all pipeline stages are cleared (active=0, syncs=1).
  - Output values during rst and the 3 clks following its release:
    - vga_hsync=1, vga_vsync=1
    - vga_red/green/blue=0
    - DP_RAM_addr_out=0
    - frame_start=0
  - Reset mid-frame aborts the frame. Timing restarts from (0,0) on the first clk after rst deasserts. No partial sync pulse may extend through reset.
- Wrap-around:
  - h_cnt 799->0 and v_cnt 524->0 occur in the same clk at frame end.
  - No extra or missing clk at the wrap.
- Read-only: the block never writes the RAM and has no handshake with the capture side. Tearing against concurrent writes is accepted.

Test Plan:
- Reset: hold rst 5 clks, release. For clks 0..2 after release: outputs idle (hsync=1, vsync=1, rgb=0, addr=0). frame_start pulses at clk 3 after release.
- Line timing: count clks from frame_start. vga_hsync falls at offset 656, stays low 96 clks, rises at 752. Period is 800 clks. RGB is 0 for offsets 640..799.
- Frame timing: vga_vsync low for exactly 1600 clks starting 392000 clks after frame_start. frame_start period is 420000 clks.
- Address mapping: check DP_RAM_addr_out at these points:
  - (h=3,v=3)->0
  - (4,0)->1
  - (0,4)->160
  - (639,479)->19199
  - (640,0)->0 (blank)
- Colour expansion: RAM model returns 0xE3 -> rgb F,0,F. Returns 0x1C -> 0,F,0. Returns 0x49 -> R=0100, G=0100, B=0101. Each value must appear on the pins exactly 3 clks after its stage-0 pixel.
- Mid-frame reset: assert rst at v_cnt=200, h_cnt=700, during hsync low. hsync=1 on the next clk. After release, the next frame_start arrives 3 clks later and the full line/frame timing is re-verified.
